// File: rtl/multicycle_datapath_pkg.sv
// multicycle_datapath_pkg: TSC ISA encodings, FSM states and ALU op codes
package multicycle_datapath_pkg;
  localparam int WORD_SIZE = 16;
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;
  localparam logic [2:0] S_IF = 3'd0;
  localparam logic [2:0] S_ID = 3'd1;
  localparam logic [2:0] S_EX = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;
  localparam logic [2:0] S_ERR = 3'd6;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;
  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction
endpackage

// File: rtl/multicycle_datapath_alu_unit.sv
// alu_unit: combinational 16-bit ALU with equality and signed zero-compare flags
module alu_unit
  import multicycle_datapath_pkg::*;
(
  input  logic [3:0]           op_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic [WORD_SIZE-1:0] y_o,
  output logic                 eq_o,
  output logic                 gtz_o,
  output logic                 ltz_o
);
  always_comb begin
    case (op_i)
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_ORR:   y_o = a_i | b_i;
      ALU_NOT:   y_o = ~a_i;
      ALU_TCP:   y_o = -a_i;
      ALU_SHL:   y_o = {a_i[WORD_SIZE-2:0], 1'b0};
      ALU_SHR:   y_o = {a_i[WORD_SIZE-1], a_i[WORD_SIZE-1:1]};
      ALU_PASSB: y_o = b_i;
      default:   y_o = a_i + b_i;
    endcase
  end
  assign eq_o = a_i == b_i;
  assign ltz_o = a_i[WORD_SIZE-1];
  assign gtz_o = !a_i[WORD_SIZE-1] && |a_i;
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: IF/ID/EX/MEM/WB TSC datapath on a handshaked shared tristate bus
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          LINK_REG    = 2,
  parameter int          MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        readM,
  output logic        writeM,
  output logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        inputReady,
  input  logic        ackOutput,
  output logic [15:0] output_port,
  output logic [15:0] num_inst,
  output logic        is_halted,
  output logic        mem_err
);
  localparam logic [1:0] LINK = 2'(LINK_REG);
  logic [2:0] state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0] port_q, port_d, num_q, num_d, tmo_q, tmo_d;
  logic readm_q, readm_d, writem_q, writem_d;
  logic [15:0] rf_q [4];
  logic [3:0] op, alu_op;
  logic [1:0] rs, rt, rd, wb_dst;
  logic [5:0] fn;
  logic [7:0] imm;
  logic [15:0] alu_b, alu_y, target;
  logic is_r, r_alu, is_link, wb_en, eq, gtz, ltz, taken, rd_ack, wr_ack, waiting;
  assign op = ir_q[15:12];
  assign rs = ir_q[11:10];
  assign rt = ir_q[9:8];
  assign rd = ir_q[7:6];
  assign fn = ir_q[5:0];
  assign imm = ir_q[7:0];
  assign is_r = op == OP_RTYPE;
  assign r_alu = is_r && fn <= FN_SHR;
  assign is_link = op == OP_JAL || (is_r && fn == FN_JRL);
  assign wb_en = r_alu || op == OP_ADI || op == OP_ORI || op == OP_LHI || op == OP_LWD || is_link;
  assign wb_dst = is_link ? LINK : r_alu ? rd : rt;
  assign alu_op = r_alu ? fn[3:0] : op == OP_ORI ? ALU_ORR : op == OP_LHI ? ALU_PASSB : ALU_ADD;
  assign alu_b = (is_r || op <= OP_BLZ) ? b_q : op == OP_ORI ? {8'h00, imm} :
                 op == OP_LHI ? {imm, 8'h00} : sext8(imm);
  assign target = pc_q + sext8(imm);
  assign taken = op == OP_BNE ? !eq : op == OP_BEQ ? eq : op == OP_BGZ ? gtz : ltz;
  assign rd_ack = readm_q && inputReady;
  assign wr_ack = writem_q && ackOutput;
  assign waiting = (readm_q && !inputReady) || (writem_q && !ackOutput);
  alu_unit u_alu (
    .op_i (alu_op),
    .a_i  (a_q),
    .b_i  (alu_b),
    .y_o  (alu_y),
    .eq_o (eq),
    .gtz_o(gtz),
    .ltz_o(ltz)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    port_d = port_q;
    num_d = num_q;
    case (state_q)
      S_IF: if (rd_ack) begin
        ir_d = data;
        state_d = S_ID;
      end
      S_ID: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        pc_d = pc_q + 16'd1;
        num_d = num_q + 16'd1;
        state_d = (is_r && fn == FN_HLT) ? S_HALT : S_EX;
      end
      S_EX: begin
        res_d = is_link ? pc_q : alu_y;
        state_d = (op == OP_LWD || op == OP_SWD) ? S_MEM : wb_en ? S_WB : S_IF;
        if (op <= OP_BLZ && taken) pc_d = target;
        if (op == OP_JMP || op == OP_JAL) pc_d = {pc_q[15:12], ir_q[11:0]};
        if (is_r && (fn == FN_JPR || fn == FN_JRL)) pc_d = a_q;
        if (is_r && fn == FN_WWD) port_d = a_q;
      end
      S_MEM: if (rd_ack) begin
        res_d = data;
        state_d = S_WB;
      end else if (wr_ack) state_d = S_IF;
      S_WB: state_d = S_IF;
      default: ;
    endcase
    tmo_d = waiting ? tmo_q + 16'd1 : 16'd0;
    if (MEM_TIMEOUT != 0 && waiting && int'(tmo_q) == MEM_TIMEOUT - 1) state_d = S_ERR;
    readm_d = state_d == S_IF || (state_d == S_MEM && op == OP_LWD);
    writem_d = state_d == S_MEM && op == OP_SWD;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IF;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      port_q <= '0;
      num_q <= '0;
      tmo_q <= '0;
      readm_q <= 1'b0;
      writem_q <= 1'b0;
      rf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      port_q <= port_d;
      num_q <= num_d;
      tmo_q <= tmo_d;
      readm_q <= readm_d;
      writem_q <= writem_d;
      if (state_q == S_WB && wb_en) rf_q[wb_dst] <= res_q;
    end
  assign readM = readm_q;
  assign writeM = writem_q;
  assign address = state_q == S_MEM ? res_q : pc_q;
  assign data = writem_q ? b_q : 16'hzzzz;
  assign output_port = port_q;
  assign num_inst = num_q;
  assign is_halted = state_q == S_HALT;
  assign mem_err = state_q == S_ERR;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench; program run on one DUT, timeout probed on a second
module tb_multicycle_datapath;
  typedef struct {
    logic [1:0]  k;
    logic [15:0] a;
    logic [15:0] d;
    int          n;
  } ev_t;
  ev_t exp_q[$];
  int tests = 0;
  int failed = 0;
  logic clk = 1'b0;
  logic reset_n;
  logic readM, writeM, inputReady, ackOutput, is_halted, mem_err;
  logic [15:0] address, output_port, num_inst, rd_val;
  wire  [15:0] bus;
  logic readM2, writeM2, is_halted2, mem_err2;
  logic ir2 = 1'b0;
  logic ack2 = 1'b0;
  logic [15:0] address2, port2, num2;
  wire  [15:0] bus2;
  logic [15:0] imem [65536];
  logic [15:0] dmem [16];
  int wcnt = 0;
  logic data_region;
  always #5 clk = ~clk;
  multicycle_datapath #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM), .address(address),
    .data(bus), .inputReady(inputReady), .ackOutput(ackOutput), .output_port(output_port),
    .num_inst(num_inst), .is_halted(is_halted), .mem_err(mem_err)
  );
  multicycle_datapath #(.MEM_TIMEOUT(4)) dut_tmo (
    .clk(clk), .reset_n(reset_n), .readM(readM2), .writeM(writeM2), .address(address2),
    .data(bus2), .inputReady(ir2), .ackOutput(ack2), .output_port(port2),
    .num_inst(num2), .is_halted(is_halted2), .mem_err(mem_err2)
  );
  // Data window 0x0040-0x004F answers after two wait cycles, everything else at once.
  assign data_region = address[15:4] == 12'h004;
  assign inputReady = readM && (data_region ? wcnt >= 2 : 1'b1);
  assign ackOutput = writeM && (data_region ? wcnt >= 2 : 1'b1);
  assign rd_val = data_region ? dmem[address[3:0]] : imem[address];
  assign bus = (readM && !writeM) ? rd_val : 16'hzzzz;
  always @(posedge clk) begin
    wcnt <= ((readM && !inputReady) || (writeM && !ackOutput)) ? wcnt + 1 : 0;
    if (writeM && ackOutput) dmem[address[3:0]] <= bus;
  end
  function automatic logic [15:0] rt_i(input logic [5:0] fn, input logic [1:0] rs, rt, rd);
    return {4'hF, rs, rt, rd, fn};
  endfunction
  function automatic logic [15:0] it_i(input logic [3:0] op, input logic [1:0] rs, rt, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic push(input logic [1:0] k, input logic [15:0] a, d, input int n);
    ev_t e;
    e.k = k;
    e.a = a;
    e.d = d;
    e.n = n;
    exp_q.push_back(e);
  endtask
  task automatic exp_rd(input logic [15:0] a);
    push(2'd0, a, 16'h0, 0);
  endtask
  task automatic exp_port(input logic [15:0] d, input int n);
    push(2'd2, 16'h0, d, n);
  endtask
  task automatic check_ev(input logic [1:0] k, input logic [15:0] a, d, input int n);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL event: unexpected kind=%0d addr=%h data=%h n=%0d", k, a, d, n);
    end else begin
      e = exp_q.pop_front();
      if (e.k !== k || e.a !== a || e.d !== d || e.n != n) begin
        failed++;
        $display("FAIL event: got kind=%0d addr=%h data=%h n=%0d, expected kind=%0d addr=%h data=%h n=%0d",
                 k, a, d, n, e.k, e.a, e.d, e.n);
      end
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  initial begin
    logic rd_prev = 1'b0;
    logic [15:0] port_prev = 16'h0;
    int wc = 0;
    forever begin
      @(negedge clk);
      if (output_port !== port_prev) begin
        check_ev(2'd2, 16'h0, output_port, int'(num_inst));
        port_prev = output_port;
      end
      if (!writeM) wc = 0;
      else begin
        wc++;
        if (ackOutput) check_ev(2'd1, address, bus, wc);
      end
      if (readM && !rd_prev) check_ev(2'd0, address, 16'h0, 0);
      rd_prev = readM;
    end
  end
  int t_cyc = 0;
  int t_rises = 0;
  logic [15:0] t_addr = 16'hFFFF;
  initial begin
    logic t_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (readM2) t_cyc++;
      if (readM2 && !t_prev) begin
        t_rises++;
        if (t_rises == 1) t_addr = address2;
      end
      t_prev = readM2;
    end
  end
  initial begin
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    imem[16'h0010] = it_i(4'd6, 2'd0, 2'd1, 8'h12);
    imem[16'h0011] = it_i(4'd5, 2'd1, 2'd1, 8'h34);
    imem[16'h0012] = rt_i(6'd28, 2'd1, 2'd0, 2'd0);
    imem[16'h0013] = it_i(4'd4, 2'd0, 2'd0, 8'hFF);
    imem[16'h0014] = it_i(4'd3, 2'd0, 2'd0, 8'h02);
    imem[16'h0015] = rt_i(6'd28, 2'd0, 2'd0, 2'd0);
    imem[16'h0016] = rt_i(6'd28, 2'd0, 2'd0, 2'd0);
    imem[16'h0017] = it_i(4'd4, 2'd0, 2'd0, 8'h01);
    imem[16'h0018] = it_i(4'd2, 2'd0, 2'd0, 8'h05);
    imem[16'h0019] = it_i(4'd4, 2'd0, 2'd1, 8'h40);
    imem[16'h001A] = it_i(4'd6, 2'd0, 2'd2, 8'hAB);
    imem[16'h001B] = it_i(4'd5, 2'd2, 2'd2, 8'hCD);
    imem[16'h001C] = it_i(4'd8, 2'd1, 2'd2, 8'h03);
    imem[16'h001D] = it_i(4'd7, 2'd1, 2'd3, 8'h03);
    imem[16'h001E] = rt_i(6'd28, 2'd3, 2'd0, 2'd0);
    imem[16'h001F] = it_i(4'd6, 2'd0, 2'd1, 8'h10);
    imem[16'h0020] = it_i(4'd5, 2'd1, 2'd1, 8'h05);
    imem[16'h0021] = rt_i(6'd25, 2'd1, 2'd0, 2'd0);
    imem[16'h1005] = {4'd10, 12'h040};
    imem[16'h1040] = rt_i(6'd28, 2'd2, 2'd0, 2'd0);
    imem[16'h1041] = rt_i(6'd26, 2'd2, 2'd0, 2'd0);
    imem[16'h1006] = rt_i(6'd28, 2'd2, 2'd0, 2'd0);
    imem[16'h1007] = rt_i(6'd7, 2'd3, 2'd0, 2'd0);
    imem[16'h1008] = rt_i(6'd28, 2'd0, 2'd0, 2'd0);
    imem[16'h1009] = rt_i(6'd1, 2'd1, 2'd2, 2'd0);
    imem[16'h100A] = rt_i(6'd28, 2'd0, 2'd0, 2'd0);
    imem[16'h100B] = it_i(4'd0, 2'd0, 2'd1, 8'h01);
    imem[16'h100C] = rt_i(6'd28, 2'd1, 2'd0, 2'd0);
    imem[16'h100D] = it_i(4'd1, 2'd0, 2'd0, 8'h02);
    imem[16'h1010] = rt_i(6'd5, 2'd1, 2'd0, 2'd2);
    imem[16'h1011] = rt_i(6'd28, 2'd2, 2'd0, 2'd0);
    imem[16'h1012] = rt_i(6'd40, 2'd0, 2'd0, 2'd0);
    imem[16'h1013] = rt_i(6'd29, 2'd0, 2'd0, 2'd0);
    exp_rd(16'h0010); exp_rd(16'h0011); exp_rd(16'h0012); exp_port(16'h1234, 3);
    exp_rd(16'h0013); exp_rd(16'h0014); exp_rd(16'h0017); exp_rd(16'h0018);
    exp_rd(16'h0019); exp_rd(16'h001A); exp_rd(16'h001B); exp_rd(16'h001C);
    push(2'd1, 16'h0043, 16'hABCD, 3);
    exp_rd(16'h001D); exp_rd(16'h0043); exp_rd(16'h001E); exp_port(16'hABCD, 13);
    exp_rd(16'h001F); exp_rd(16'h0020); exp_rd(16'h0021); exp_rd(16'h1005);
    exp_rd(16'h1040); exp_port(16'h1006, 18); exp_rd(16'h1041); exp_rd(16'h1006);
    exp_port(16'h1042, 20); exp_rd(16'h1007); exp_rd(16'h1008); exp_port(16'hD5E6, 22);
    exp_rd(16'h1009); exp_rd(16'h100A); exp_port(16'hFFC3, 24); exp_rd(16'h100B);
    exp_rd(16'h100D); exp_rd(16'h1010); exp_rd(16'h1011); exp_port(16'hEFFB, 28);
    exp_rd(16'h1012); exp_rd(16'h1013);
    repeat (3) @(negedge clk);
    chk("rst_readM", readM, 1'b0);
    chk("rst_writeM", writeM, 1'b0);
    chk("rst_num_inst", num_inst, 16'h0);
    chk("rst_output_port", output_port, 16'h0);
    chk("rst_is_halted", is_halted, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_address", address, 16'h0010);
    reset_n = 1'b1;
    for (int i = 0; i < 3000 && !is_halted; i++) @(negedge clk);
    chk("halt_reached", is_halted, 1'b1);
    repeat (20) @(negedge clk);
    chk("halt_readM", readM, 1'b0);
    chk("final_num_inst", num_inst, 16'd30);
    chk("final_output_port", output_port, 16'hEFFB);
    chk("final_mem_err", mem_err, 1'b0);
    chk("events_left", exp_q.size(), 0);
    chk("tmo_first_addr", t_addr, 16'h0000);
    chk("tmo_readM_cycles", t_cyc, 4);
    chk("tmo_request_count", t_rises, 1);
    chk("tmo_mem_err", mem_err2, 1'b1);
    chk("tmo_readM", readM2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
